demux_rr_arbiter: RTL and testbench
===================================

# demux_rr_arbiter

Round-robin arbiter and sequencer for the 1x8 tri-state demux stage. Up to eight requesters share the demux output. The arbiter grants one requester at a time for a bounded dwell, and drives the demux `sel`/`entrada`/`enable` inputs with break-before-make gaps. It also drives the 12-bit display bus with the granted channel number.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clock cycles per dwell tick; minimum 2.
- `DWELL`, default 4: ticks per grant; minimum 1.

Ports:
- `clk`  in  1  system clock.
- `clear`  in  1  synchronous, active-high reset.
- `req`  in  8  request per channel; level-sensitive.
- `din`  in  8  data bit per channel.
- `sel`  out  3  demux select; equals the granted channel index.
- `entrada`  out  1  registered data to the demux.
- `enable`  out  1  demux disable; 1 means demux outputs are Z.
- `grant`  out  8  one-hot grant; 0 when idle.
- `busy`  out  1  high in GRANT.
- `disp`  out  12  {segments a..g,dp active-low, anodes[3:0] active-low}.

## Operation
State machine: IDLE, GRANT, GAP.

- **IDLE:**
  - Outputs: `enable`=1, `grant`=0, `entrada`=0.
  - If `req`≠0, the next edge performs the following:
    - Select the winner: the first set bit searching upward from `last`+1, wrapping 7→0.
    - Load `sel`=winner, `grant`=1<<winner, `last`=winner.
    - Clear the prescaler and the dwell counter.
    - Drive `enable`=0 and go to GRANT.
- **GRANT:**
  - Each cycle, `entrada` <= `din[sel]`, a 1-cycle registered path.
  - The prescaler counts 0..`TICK_DIV`-1. At `TICK_DIV`-1 it raises `tick`, and the dwell counter increments.
  - Exit to GAP on the next edge when either condition holds:
    - `req[sel]`==0.
    - `tick` is high and the dwell count equals `DWELL`-1.
- **GAP:**
  - Lasts exactly one cycle. Outputs are as in IDLE.
  - Goes to IDLE unconditionally.
- Minimum demux-disabled interval between grants is 2 cycles (GAP + IDLE). There is no back-to-back grant without a gap.
- A single persistent requester is re-granted after every gap.
- `req` changes on channels other than `sel` have no effect during GRANT.
- `sel` holds its last value in IDLE/GAP. The demux is disabled then, so this is harmless.
- Display:
  - In GRANT: `disp[3:0]`=4'b1110 and `disp[11:4]`=hex7seg(`sel`). Examples: 0→8'b00000011, 1→8'b10011111, 3→8'b00001101, 7→8'b00011111.
  - Otherwise: `disp`=12'hFFF.

## Timing
- Reset, synchronous on `clear`=1, takes effect at the next edge:
  - State IDLE, `last`=7 (so channel 0 has first priority).
  - `sel`=0, `entrada`=0, `enable`=1, `grant`=0, `busy`=0, `disp`=12'hFFF.
  - Prescaler and dwell counter at 0.
- `clear` asserted mid-GRANT forces the reset values at that edge, with no GAP cycle.
- Request-to-grant latency is 1 cycle from the edge sampling `req`≠0 in IDLE.
- Full dwell in GRANT is exactly `DWELL`×`TICK_DIV` cycles.
- A `req[sel]` drop is seen on the next edge, so GRANT ends 1 cycle after the drop.
- If `req[sel]` drops on the same cycle as the final tick, the result is a single exit to GAP.
- `entrada` lags `din[sel]` by 1 cycle. It is 0 in the first GRANT cycle only if it was 0 before; it is cleared on leaving GRANT.
- Counter widths: prescaler `$clog2(TICK_DIV)`, dwell `$clog2(DWELL+1)`.
- All outputs are registered except `disp` (combinational decode of registered `sel`/state) and `busy`.

## Structure
- The shared package `demux_pkg` holds:
  - The state enum (IDLE/GRANT/GAP).
  - `DISP_OFF`=12'hFFF.
  - `ANODE_D0`=4'b1110.
  - The 8-entry active-low segment constant table.
- One sub-module, `hex7seg`: 3-bit index in, 8-bit active-low segments out, purely combinational.
- The round-robin search stays in the arbiter as a function.

## Test plan
Benches use `TICK_DIV`=4 and `DWELL`=3.
- **Reset:** `clear`=1 for 2 cycles with `req`=8'hFF → all outputs at reset values; the first grant after release goes to channel 0, with `grant`=8'h01 and `disp`=12'h03E.
- **Full dwell:** `req`=8'h08 held, `din[3]` toggling → `busy` high for exactly 12 cycles, `sel`=3, `entrada` tracks `din[3]` delayed 1 cycle; then `enable`=1 for 2 cycles, then re-grant of channel 3.
- **Rotation:** `req`=8'h85 held → grant order 0, 2, 7, 0, each grant 12 cycles with a 2-cycle gap between grants.
- **Early release:** grant on channel 1, `req[1]` dropped at GRANT cycle 5 → GAP at cycle 6, `grant`=0, `entrada`=0.
- **Non-granted requests ignored:** grant on channel 5, `req[4]` raised mid-GRANT → channel 5 keeps its grant until its dwell expires; the next winner is channel 4 only if no requester in 6..7 or 0..3 is pending.
- **Mid-grant clear:** `clear` pulsed on GRANT cycle 7 → `enable`=1 and `grant`=0 on the next edge; `last` resets, so with `req`=8'hFF the next winner is channel 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the demux round-robin arbiter.
// Contents: FSM state enum, display constants, and the active-low
// seven-segment table for channel indices 0..7.
package demux_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam logic [11:0] DISP_OFF = 12'hFFF;
    localparam logic [3:0]  ANODE_D0 = 4'b1110;

    // {a,b,c,d,e,f,g,dp}, active-low. Entry [i] is the glyph for digit i.
    localparam logic [7:0][7:0] SEG_TABLE = {
        8'b00011111,  // 7
        8'b01000001,  // 6
        8'b01001001,  // 5
        8'b10011001,  // 4
        8'b00001101,  // 3
        8'b00100101,  // 2
        8'b10011111,  // 1
        8'b00000011   // 0
    };

endpackage

// File: rtl/demux_rr_arbiter_if.sv
// Bus between the arbiter, the requesters and the demux/display.
//   req, din       : per-channel request level and data bit (into arbiter)
//   sel, entrada,
//   enable         : demux controls (enable=1 puts demux outputs in Z)
//   grant, busy    : one-hot grant and grant-active flag
//   disp           : {segments a..g,dp, anodes[3:0]}, all active-low
// master = arbiter side, slave = requester/demux side.
interface demux_rr_arbiter_if;
    logic [7:0]  req;
    logic [7:0]  din;
    logic [2:0]  sel;
    logic        entrada;
    logic        enable;
    logic [7:0]  grant;
    logic        busy;
    logic [11:0] disp;

    modport master (
        input  req, din,
        output sel, entrada, enable, grant, busy, disp
    );

    modport slave (
        output req, din,
        input  sel, entrada, enable, grant, busy, disp
    );
endinterface

// File: rtl/demux_rr_arbiter_hex7seg.sv
// Channel index to active-low seven-segment glyph, purely combinational.
//   idx : channel index 0..7
//   seg : {a,b,c,d,e,f,g,dp}, active-low
module hex7seg
    import demux_pkg::*;
(
    input  logic [2:0] idx,
    output logic [7:0] seg
);
    assign seg = SEG_TABLE[idx];
endmodule

// File: rtl/demux_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 1x8 tri-state demux stage.
// Grants one requester at a time for at most DWELL*TICK_DIV cycles and
// separates grants with a GAP+IDLE break-before-make interval.
//   clk   : system clock
//   clear : synchronous active-high reset
//   bus   : arbiter side of demux_rr_arbiter_if
module demux_rr_arbiter
    import demux_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int DWELL    = 4
)(
    input  logic                 clk,
    input  logic                 clear,
    demux_rr_arbiter_if.master   bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DWELL + 1);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DW_LAST = DW'(DWELL - 1);

    state_t          state, state_n;
    logic [2:0]      sel, sel_n, last, last_n, win;
    logic [7:0]      grant, grant_n;
    logic            entrada, entrada_n, enable, enable_n;
    logic [PW-1:0]   pre, pre_n;
    logic [DW-1:0]   dwell, dwell_n;
    logic            tick;
    logic [7:0]      seg;

    // First set bit searching upward from l+1, wrapping; l itself is
    // checked last. Walking downward lets the nearest candidate win.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] l);
        logic [2:0] idx;
        rr_pick = l;
        for (int i = 8; i >= 1; i--) begin
            idx = l + 3'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign win  = rr_pick(bus.req, last);
    assign tick = (pre == PRE_MAX);

    always_comb begin
        state_n   = state;
        sel_n     = sel;
        last_n    = last;
        grant_n   = grant;
        entrada_n = entrada;
        enable_n  = enable;
        pre_n     = pre;
        dwell_n   = dwell;
        case (state)
            S_IDLE: begin
                if (|bus.req) begin
                    state_n  = S_GRANT;
                    sel_n    = win;
                    last_n   = win;
                    grant_n  = 8'b1 << win;
                    enable_n = 1'b0;
                    pre_n    = '0;
                    dwell_n  = '0;
                end
            end
            S_GRANT: begin
                pre_n = tick ? '0 : pre + 1'b1;
                if (tick) dwell_n = dwell + 1'b1;
                if (!bus.req[sel] || (tick && dwell == DW_LAST)) begin
                    state_n   = S_GAP;
                    grant_n   = '0;
                    enable_n  = 1'b1;
                    entrada_n = 1'b0;
                end else begin
                    entrada_n = bus.din[sel];
                end
            end
            S_GAP:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= S_IDLE;
            sel     <= '0;
            last    <= 3'd7;
            grant   <= '0;
            entrada <= 1'b0;
            enable  <= 1'b1;
            pre     <= '0;
            dwell   <= '0;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            last    <= last_n;
            grant   <= grant_n;
            entrada <= entrada_n;
            enable  <= enable_n;
            pre     <= pre_n;
            dwell   <= dwell_n;
        end
    end

    hex7seg u_hex7seg (.idx(sel), .seg(seg));

    assign bus.sel     = sel;
    assign bus.grant   = grant;
    assign bus.entrada = entrada;
    assign bus.enable  = enable;
    assign bus.busy    = (state == S_GRANT);
    assign bus.disp    = (state == S_GRANT) ? {seg, ANODE_D0} : DISP_OFF;

endmodule

// File: tb/tb_demux_rr_arbiter.sv
module tb_demux_rr_arbiter;
    localparam int TD   = 4;
    localparam int DWL  = 3;
    localparam int FULL = TD * DWL;

    logic clk = 1'b0;
    logic clear = 1'b1;
    demux_rr_arbiter_if bus();

    demux_rr_arbiter #(.TICK_DIV(TD), .DWELL(DWL)) dut (
        .clk(clk), .clear(clear), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    logic [7:0] seg_ref [8] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: mode 0=idle 1=grant 2=gap; cnt = grant cycle number.
    int         m_mode = 0;
    int         m_cnt  = 0;
    logic [2:0] m_sel  = 3'd0;
    logic [2:0] m_last = 3'd7;
    logic       m_ent  = 1'b0;

    always @(posedge clk) begin
        if (clear) begin
            m_mode = 0; m_cnt = 0; m_sel = 3'd0; m_last = 3'd7; m_ent = 1'b0;
        end else begin
            case (m_mode)
                0: if (bus.req != 8'h00) begin
                    for (int k = 1; k <= 8; k++) begin
                        int c;
                        c = (int'(m_last) + k) % 8;
                        if (bus.req[c]) begin
                            m_sel = 3'(c);
                            break;
                        end
                    end
                    m_last = m_sel;
                    m_mode = 1;
                    m_cnt  = 1;
                end
                1: if (!bus.req[m_sel] || m_cnt == FULL) begin
                    m_mode = 2;
                    m_ent  = 1'b0;
                end else begin
                    m_ent = bus.din[m_sel];
                    m_cnt++;
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sel",     32'(bus.sel),     32'(m_sel));
            chk("entrada", 32'(bus.entrada), 32'(m_ent));
            chk("enable",  32'(bus.enable),  32'(m_mode != 1));
            chk("grant",   32'(bus.grant),   (m_mode == 1) ? 32'(8'b1 << m_sel) : 32'h0);
            chk("busy",    32'(bus.busy),    32'(m_mode == 1));
            chk("disp",    32'(bus.disp),    (m_mode == 1) ? {20'h0, seg_ref[m_sel], 4'hE} : 32'hFFF);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        bus.din = 8'($urandom);
    endtask

    task automatic do_reset();
        clear = 1'b1;
        bus.req = 8'h00;
        step();
        clear = 1'b0;
    endtask

    // Counts GRANT cycles from the current one; returns in the GAP cycle.
    task automatic run_grant(output int n);
        n = 0;
        while (bus.busy && n < 50) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        int order [4] = '{0, 2, 7, 0};
        bus.req = 8'hFF;
        bus.din = 8'h00;

        // Reset held 2 cycles with all requests pending
        clear = 1'b1;
        step(); step();
        chk_en = 1'b1;
        chk("rst_enable", 32'(bus.enable), 32'd1);
        chk("rst_grant",  32'(bus.grant),  32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_sel",    32'(bus.sel),    32'd0);
        chk("rst_ent",    32'(bus.entrada), 32'd0);
        chk("rst_disp",   32'(bus.disp),   32'hFFF);
        clear = 1'b0;
        step();
        chk("first_grant", 32'(bus.grant), 32'h01);
        chk("first_disp",  32'(bus.disp),  32'h03E);

        // Full dwell on channel 3, then gap and re-grant
        do_reset();
        bus.req = 8'h08;
        step();
        run_grant(n);
        chk("dwell_len", n, 12);
        chk("gap_enable", 32'(bus.enable), 32'd1);
        step();
        chk("idle_enable", 32'(bus.enable), 32'd1);
        chk("idle_busy",   32'(bus.busy),   32'd0);
        step();
        chk("regrant_busy", 32'(bus.busy), 32'd1);
        chk("regrant_sel",  32'(bus.sel),  32'd3);

        // Rotation over 0,2,7
        do_reset();
        bus.req = 8'h85;
        step();
        for (int g = 0; g < 4; g++) begin
            chk("rot_sel", 32'(bus.sel), 32'(order[g]));
            run_grant(n);
            chk("rot_len", n, 12);
            if (g < 3) begin
                n = 0;
                while (!bus.busy && n < 10) begin
                    n++;
                    step();
                end
                chk("rot_gap", n, 2);
            end
        end

        // Early release on channel 1 at grant cycle 5
        do_reset();
        bus.req = 8'h02;
        step();
        chk("er_sel", 32'(bus.sel), 32'd1);
        repeat (4) step();
        chk("er_busy5", 32'(bus.busy), 32'd1);
        bus.req = 8'h00;
        step();
        chk("er_busy6",  32'(bus.busy),    32'd0);
        chk("er_grant6", 32'(bus.grant),   32'd0);
        chk("er_ent6",   32'(bus.entrada), 32'd0);
        chk("er_en6",    32'(bus.enable),  32'd1);

        // Non-granted request raised mid-grant
        do_reset();
        bus.req = 8'h20;
        step();
        n = 0;
        while (bus.busy && n < 50) begin
            if (n == 3) bus.req = 8'h30;
            n++;
            step();
        end
        chk("ng_len", n, 12);
        step(); step();
        chk("ng_next", 32'(bus.sel), 32'd4);

        // Clear at grant cycle 7 on channel 1
        do_reset();
        bus.req = 8'h02;
        step();
        repeat (6) step();
        clear = 1'b1;
        bus.req = 8'hFF;
        step();
        chk("mc_enable", 32'(bus.enable), 32'd1);
        chk("mc_grant",  32'(bus.grant),  32'd0);
        chk("mc_disp",   32'(bus.disp),   32'hFFF);
        clear = 1'b0;
        step();
        chk("mc_next_grant", 32'(bus.grant), 32'h01);
        chk("mc_next_sel",   32'(bus.sel),   32'd0);

        // Random traffic against the model
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) bus.req = 8'($urandom & $urandom);
            clear = ($urandom_range(0, 99) == 0);
            step();
        end
        clear = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
